// File: rtl/bus_arb_pkg.sv
// Shared constants for the round-robin bus arbiter: FSM encoding and default sizing.
package bus_arb_pkg;

  // Default number of requesting masters and completion timeout (cycles, 0 = off).
  localparam int unsigned NmDefault    = 3;
  localparam int unsigned ToCycDefault = 1024;

  // Width of every address / data field on both sides of the arbiter.
  localparam int unsigned FieldW = 32;

  // Arbiter FSM encoding.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIssue  = 3'd1;
  localparam logic [2:0] StWaitRd = 3'd2;
  localparam logic [2:0] StWaitWr = 3'd3;
  localparam logic [2:0] StGap    = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping at NM.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned NM = NmDefault,
  parameter int unsigned IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [NM-1:0] gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // Scan NM positions starting at ptr; the first hit wins.
  always_comb begin
    logic [IW:0] pos;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    pos     = '0;
    for (int k = 0; k < NM; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NM)) begin
        pos = pos - (IW+1)'(NM);
      end
      if (!gnt_vld && req[pos[IW-1:0]]) begin
        gnt_vld                 = 1'b1;
        gnt_oh[pos[IW-1:0]]     = 1'b1;
        gnt_idx                 = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arb_rr.sv
// Round-robin arbiter funnelling NM masters onto one downstream read/write port.
// One transaction at a time; a one-cycle gap after each completion lets the
// served master drop its request before the next decision.
module bus_arb_rr
  import bus_arb_pkg::*;
#(
  parameter int unsigned NM     = NmDefault,
  parameter int unsigned TO_CYC = ToCycDefault
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Master side
  input  logic [NM-1:0]        m_read_req,
  input  logic [NM-1:0]        m_write_req,
  input  logic [NM-1:0]        m_read_w,
  input  logic [NM-1:0]        m_read_hw,
  input  logic [NM-1:0]        m_write_w,
  input  logic [NM-1:0]        m_write_hw,
  input  logic [NM*FieldW-1:0] m_read_adr,
  input  logic [NM*FieldW-1:0] m_write_adr,
  input  logic [NM*FieldW-1:0] m_write_data,
  output logic [NM-1:0]        m_read_valid,
  output logic [NM-1:0]        m_write_finish,
  output logic [NM-1:0]        m_err,
  output logic [FieldW-1:0]    m_read_data,
  // Downstream side
  output logic                 read_req,
  output logic                 write_req,
  output logic                 read_w,
  output logic                 read_hw,
  output logic                 write_w,
  output logic                 write_hw,
  output logic [FieldW-1:0]    read_adr,
  output logic [FieldW-1:0]    write_adr,
  output logic [FieldW-1:0]    write_data,
  input  logic                 read_valid,
  input  logic                 write_finish,
  input  logic [FieldW-1:0]    read_data
);

  localparam int unsigned IW     = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned CW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int unsigned ToLast = (TO_CYC == 0) ? 0 : TO_CYC - 1;
  localparam bit          ToEn   = (TO_CYC != 0);

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     g_q, g_d;
  logic              op_wr_q, op_wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FieldW-1:0] rd_adr_q, rd_adr_d;
  logic              rd_w_q, rd_w_d;
  logic              rd_hw_q, rd_hw_d;
  logic [FieldW-1:0] wr_adr_q, wr_adr_d;
  logic [FieldW-1:0] wr_data_q, wr_data_d;
  logic              wr_w_q, wr_w_d;
  logic              wr_hw_q, wr_hw_d;

  logic [NM-1:0]     req_any;
  logic [NM-1:0]     pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;

  logic              sel_wr;
  logic [FieldW-1:0] sel_rd_adr, sel_wr_adr, sel_wr_data;
  logic              sel_rd_w, sel_rd_hw, sel_wr_w, sel_wr_hw;

  logic [NM-1:0]     g_oh;
  logic [IW-1:0]     nxt_ptr;
  logic              rd_done, wr_done, in_wait, to_hit, to_fire;

  assign req_any = m_read_req | m_write_req;

  rr_pick #(
    .NM (NM),
    .IW (IW)
  ) u_rr_pick (
    .req     (req_any),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Mux the picked master's fields; a master with both requests is served as a write first.
  always_comb begin
    sel_rd_adr  = '0;
    sel_wr_adr  = '0;
    sel_wr_data = '0;
    sel_rd_w    = 1'b0;
    sel_rd_hw   = 1'b0;
    sel_wr_w    = 1'b0;
    sel_wr_hw   = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (pick_oh[i]) begin
        sel_rd_adr  = m_read_adr[FieldW*i +: FieldW];
        sel_wr_adr  = m_write_adr[FieldW*i +: FieldW];
        sel_wr_data = m_write_data[FieldW*i +: FieldW];
        sel_rd_w    = m_read_w[i];
        sel_rd_hw   = m_read_hw[i];
        sel_wr_w    = m_write_w[i];
        sel_wr_hw   = m_write_hw[i];
      end
    end
    sel_wr = |(pick_oh & m_write_req);
  end

  // Completion / timeout qualifiers; a real completion beats a coincident timeout.
  always_comb begin
    g_oh       = '0;
    g_oh[g_q]  = 1'b1;
    nxt_ptr    = (g_q == IW'(NM - 1)) ? '0 : g_q + IW'(1);
    rd_done    = (state_q == StWaitRd) && read_valid;
    wr_done    = (state_q == StWaitWr) && write_finish;
    in_wait    = (state_q == StWaitRd) || (state_q == StWaitWr);
    to_hit     = ToEn && in_wait && (cnt_q == CW'(ToLast));
    to_fire    = to_hit && !rd_done && !wr_done;
  end

  // Next-state: grant in IDLE, pulse in ISSUE, wait for completion or timeout, then gap.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    op_wr_d   = op_wr_q;
    cnt_d     = cnt_q;
    rd_adr_d  = rd_adr_q;
    rd_w_d    = rd_w_q;
    rd_hw_d   = rd_hw_q;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    wr_w_d    = wr_w_q;
    wr_hw_d   = wr_hw_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          g_d     = pick_idx;
          op_wr_d = sel_wr;
          if (sel_wr) begin
            wr_adr_d  = sel_wr_adr;
            wr_data_d = sel_wr_data;
            wr_w_d    = sel_wr_w;
            wr_hw_d   = sel_wr_hw;
          end else begin
            rd_adr_d = sel_rd_adr;
            rd_w_d   = sel_rd_w;
            rd_hw_d  = sel_rd_hw;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = op_wr_q ? StWaitWr : StWaitRd;
      end
      StWaitRd, StWaitWr: begin
        if (rd_done || wr_done || to_fire) begin
          ptr_d   = nxt_ptr;
          state_d = StGap;
        end else if (ToEn) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and captured transaction fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      g_q       <= '0;
      op_wr_q   <= 1'b0;
      cnt_q     <= '0;
      rd_adr_q  <= '0;
      rd_w_q    <= 1'b0;
      rd_hw_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      wr_w_q    <= 1'b0;
      wr_hw_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      op_wr_q   <= op_wr_d;
      cnt_q     <= cnt_d;
      rd_adr_q  <= rd_adr_d;
      rd_w_q    <= rd_w_d;
      rd_hw_q   <= rd_hw_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
      wr_w_q    <= wr_w_d;
      wr_hw_q   <= wr_hw_d;
    end
  end

  // Outputs: request pulses from state, strobes steered to the granted master.
  always_comb begin
    read_req       = (state_q == StIssue) && !op_wr_q;
    write_req      = (state_q == StIssue) && op_wr_q;
    m_read_valid   = rd_done ? g_oh : '0;
    m_write_finish = wr_done ? g_oh : '0;
    m_err          = to_fire ? g_oh : '0;
    // Gated so the bus stays quiet (and zero in reset) outside a completion.
    m_read_data    = rd_done ? read_data : '0;
    read_adr       = rd_adr_q;
    read_w         = rd_w_q;
    read_hw        = rd_hw_q;
    write_adr      = wr_adr_q;
    write_data     = wr_data_q;
    write_w        = wr_w_q;
    write_hw       = wr_hw_q;
  end

endmodule

// File: tb/tb_bus_arb_rr.sv
// Bench for bus_arb_rr: directed scenarios plus a randomized run against a
// transaction-level round-robin reference model.
module tb_bus_arb_rr;

  localparam int NM = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NM-1:0] m_read_req, m_write_req, m_read_w, m_read_hw, m_write_w, m_write_hw;
  logic [NM*32-1:0] m_read_adr, m_write_adr, m_write_data;
  logic [NM-1:0] m_read_valid, m_write_finish, m_err;
  logic [31:0] m_read_data;
  logic read_req, write_req, read_w, read_hw, write_w, write_hw;
  logic [31:0] read_adr, write_adr, write_data;
  logic read_valid, write_finish;
  logic [31:0] read_data;
  logic [142:0] allout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign allout = {m_read_valid, m_write_finish, m_err, m_read_data, read_req, write_req,
                   read_w, read_hw, write_w, write_hw, read_adr, write_adr, write_data};

  bus_arb_rr #(
    .NM     (NM),
    .TO_CYC (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m_read_req     (m_read_req),
    .m_write_req    (m_write_req),
    .m_read_w       (m_read_w),
    .m_read_hw      (m_read_hw),
    .m_write_w      (m_write_w),
    .m_write_hw     (m_write_hw),
    .m_read_adr     (m_read_adr),
    .m_write_adr    (m_write_adr),
    .m_write_data   (m_write_data),
    .m_read_valid   (m_read_valid),
    .m_write_finish (m_write_finish),
    .m_err          (m_err),
    .m_read_data    (m_read_data),
    .read_req       (read_req),
    .write_req      (write_req),
    .read_w         (read_w),
    .read_hw        (read_hw),
    .write_w        (write_w),
    .write_hw       (write_hw),
    .read_adr       (read_adr),
    .write_adr      (write_adr),
    .write_data     (write_data),
    .read_valid     (read_valid),
    .write_finish   (write_finish),
    .read_data      (read_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_read_req = '0; m_write_req = '0; m_read_w = '0; m_read_hw = '0;
    m_write_w = '0; m_write_hw = '0; m_read_adr = '0; m_write_adr = '0;
    m_write_data = '0; read_valid = 1'b0; write_finish = 1'b0; read_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Step until the requested downstream pulse is seen, at most 16 cycles.
  task automatic wait_pulse(input bit wr, output int n);
    n = 0;
    while (!(wr ? write_req : read_req) && n < 16) begin
      step();
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_read_req = NM'($urandom); m_write_req = NM'($urandom);
      m_read_adr = {$urandom, $urandom, $urandom}; m_write_adr = {$urandom, $urandom, $urandom};
      m_write_data = {$urandom, $urandom, $urandom}; m_read_w = NM'($urandom);
      read_valid = 1'b1; write_finish = 1'b1; read_data = $urandom;
      #1;
      n_cmp++;
      if (allout !== '0) begin
        n_bad++; $display("FAIL reset_outputs: got %h want 0", allout);
      end
      step();
    end
  endtask

  task automatic test_read_single();
    do_reset();
    m_read_req[1] = 1'b1; m_read_adr[63:32] = 32'h100; m_read_w[1] = 1'b1;
    #1;
    n_cmp++;
    if (read_req !== 1'b0) begin n_bad++; $display("FAIL rd1_early: got %b want 0", read_req); end
    step(); #1;
    n_cmp++;
    if ({read_req, write_req, read_w, read_hw} !== 4'b1010) begin
      n_bad++; $display("FAIL rd1_pulse: got %b want 1010", {read_req, write_req, read_w, read_hw});
    end
    n_cmp++;
    if (read_adr !== 32'h100) begin n_bad++; $display("FAIL rd1_adr: got %h want 100", read_adr); end
    for (int k = 1; k <= 4; k++) begin
      step(); #1;
      n_cmp++;
      if ({read_req, write_req, m_read_valid, m_err} !== '0) begin
        n_bad++; $display("FAIL rd1_wait: got %b want 0", {read_req, write_req, m_read_valid, m_err});
      end
    end
    step(); read_valid = 1'b1; read_data = 32'hDEADBEEF; #1;
    n_cmp++;
    if (m_read_valid !== 3'b010) begin
      n_bad++; $display("FAIL rd1_valid: got %b want 010", m_read_valid);
    end
    n_cmp++;
    if (m_read_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL rd1_data: got %h want deadbeef", m_read_data);
    end
    n_cmp++;
    if (read_adr !== 32'h100) begin n_bad++; $display("FAIL rd1_adr_hold: got %h want 100", read_adr); end
    step(); read_valid = 1'b0; m_read_req = '0; #1;
    n_cmp++;
    if (m_read_valid !== 3'b000) begin n_bad++; $display("FAIL rd1_gap: got %b want 000", m_read_valid); end
  endtask

  task automatic test_write_rr();
    int n;
    int exp_m;
    do_reset();
    m_write_req = 3'b111; m_write_w = 3'b111;
    for (int i = 0; i < NM; i++) begin
      m_write_adr[32*i +: 32] = 32'h1000 + 32'(16 * i);
      m_write_data[32*i +: 32] = 32'hA0A0_0000 + 32'(i);
    end
    #1;
    for (int gi = 0; gi < 4; gi++) begin
      exp_m = gi % NM;
      wait_pulse(1'b1, n);
      n_cmp++;
      if (n !== ((gi == 0) ? 1 : 2)) begin
        n_bad++; $display("FAIL wrr_latency%0d: got %0d want %0d", gi, n, (gi == 0) ? 1 : 2);
      end
      n_cmp++;
      if ({write_adr, write_data, read_req} !== {m_write_adr[32*exp_m +: 32],
                                                  m_write_data[32*exp_m +: 32], 1'b0}) begin
        n_bad++; $display("FAIL wrr_grant%0d: got adr %h want master %0d", gi, write_adr, exp_m);
      end
      step(); #1;
      n_cmp++;
      if (write_req !== 1'b0) begin n_bad++; $display("FAIL wrr_single%0d: got 1 want 0", gi); end
      step(); write_finish = 1'b1; #1;
      n_cmp++;
      if (m_write_finish !== NM'(1 << exp_m)) begin
        n_bad++; $display("FAIL wrr_finish%0d: got %b want %b", gi, m_write_finish, NM'(1 << exp_m));
      end
      step(); write_finish = 1'b0; #1;
    end
    m_write_req = '0;
  endtask

  task automatic test_both();
    int n;
    logic [31:0] rd;
    do_reset();
    m_read_req[2] = 1'b1; m_write_req[2] = 1'b1;
    m_write_adr[95:64] = 32'h20; m_read_adr[95:64] = 32'h40; m_write_data[95:64] = 32'h55AA;
    #1;
    wait_pulse(1'b1, n);
    n_cmp++;
    if ({n == 1, write_adr, read_req} !== {1'b1, 32'h20, 1'b0}) begin
      n_bad++; $display("FAIL both_wr_first: got n=%0d adr %h rq %b want 1 20 0", n, write_adr, read_req);
    end
    step(); write_finish = 1'b1; #1;
    n_cmp++;
    if ({m_write_finish, m_read_valid} !== 6'b100000) begin
      n_bad++; $display("FAIL both_wr_fin: got %b want 100000", {m_write_finish, m_read_valid});
    end
    step(); write_finish = 1'b0; m_write_req[2] = 1'b0; #1;
    wait_pulse(1'b0, n);
    n_cmp++;
    if ({n == 2, read_adr, write_req} !== {1'b1, 32'h40, 1'b0}) begin
      n_bad++; $display("FAIL both_rd_next: got n=%0d adr %h wq %b want 2 40 0", n, read_adr, write_req);
    end
    step(); step(); rd = $urandom; read_valid = 1'b1; read_data = rd; #1;
    n_cmp++;
    if ({m_read_valid, m_read_data} !== {3'b100, rd}) begin
      n_bad++; $display("FAIL both_rd_fin: got %b %h want 100 %h", m_read_valid, m_read_data, rd);
    end
    step(); read_valid = 1'b0; m_read_req = '0;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    m_read_req[0] = 1'b1; m_read_adr[31:0] = 32'h200;
    #1;
    wait_pulse(1'b0, n);
    n_cmp++;
    if (n !== 1) begin n_bad++; $display("FAIL to_pulse: got %0d want 1", n); end
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 9) m_read_req[0] = 1'b0;
      read_valid = (k == 10);
      read_data = $urandom;
      #1;
      n_cmp++;
      if (m_err !== ((k == 8) ? 3'b001 : 3'b000)) begin
        n_bad++; $display("FAIL to_err_c%0d: got %b want %b", k, m_err, (k == 8) ? 3'b001 : 3'b000);
      end
      n_cmp++;
      if ({m_read_valid, read_req} !== 4'b0000) begin
        n_bad++; $display("FAIL to_quiet_c%0d: got %b want 0000", k, {m_read_valid, read_req});
      end
    end
    read_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    m_read_req = 3'b011; m_read_adr[31:0] = 32'h300; m_read_adr[63:32] = 32'h310;
    #1;
    wait_pulse(1'b0, n);
    n_cmp++;
    if ({n == 1, read_adr} !== {1'b1, 32'h300}) begin
      n_bad++; $display("FAIL rm_first: got n=%0d adr %h want 1 300", n, read_adr);
    end
    step(); read_valid = 1'b1; read_data = $urandom; #1;
    n_cmp++;
    if (m_read_valid !== 3'b001) begin n_bad++; $display("FAIL rm_valid0: got %b want 001", m_read_valid); end
    step(); read_valid = 1'b0; #1;
    wait_pulse(1'b0, n);
    n_cmp++;
    if ({n == 2, read_adr} !== {1'b1, 32'h310}) begin
      n_bad++; $display("FAIL rm_second: got n=%0d adr %h want 2 310", n, read_adr);
    end
    step(); #1;
    rst_n = 1'b0; read_valid = 1'b1; read_data = $urandom; #1;
    n_cmp++;
    if (allout !== '0) begin n_bad++; $display("FAIL rm_in_reset: got %h want 0", allout); end
    step(); #1;
    n_cmp++;
    if (allout !== '0) begin n_bad++; $display("FAIL rm_in_reset2: got %h want 0", allout); end
    step(); rst_n = 1'b1; #1;
    n_cmp++;
    if ({m_read_valid, read_req} !== 4'b0000) begin
      n_bad++; $display("FAIL rm_late_valid: got %b want 0000", {m_read_valid, read_req});
    end
    step(); read_valid = 1'b0; #1;
    n_cmp++;
    if ({read_req, read_adr} !== {1'b1, 32'h300}) begin
      n_bad++; $display("FAIL rm_regrant: got %b %h want 1 300", read_req, read_adr);
    end
    m_read_req = '0;
  endtask

  task automatic test_spurious();
    int n;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      write_finish = 1'b1; read_valid = (k % 2 == 1); read_data = $urandom;
      #1;
      n_cmp++;
      if ({m_read_valid, m_write_finish, m_err, read_req, write_req} !== '0) begin
        n_bad++; $display("FAIL sp_idle%0d: got %b want 0", k,
                          {m_read_valid, m_write_finish, m_err, read_req, write_req});
      end
      step();
    end
    read_valid = 1'b0; write_finish = 1'b0;
    m_write_req[1] = 1'b1; m_write_adr[63:32] = 32'h7700;
    #1;
    wait_pulse(1'b1, n);
    n_cmp++;
    if ({n == 1, write_adr} !== {1'b1, 32'h7700}) begin
      n_bad++; $display("FAIL sp_grant: got n=%0d adr %h want 1 7700", n, write_adr);
    end
    for (int k = 0; k < 2; k++) begin
      step(); read_valid = 1'b1; #1;
      n_cmp++;
      if ({m_read_valid, m_write_finish, m_err} !== '0) begin
        n_bad++; $display("FAIL sp_wrong_strobe%0d: got %b want 0", k,
                          {m_read_valid, m_write_finish, m_err});
      end
    end
    step(); read_valid = 1'b0; write_finish = 1'b1; #1;
    n_cmp++;
    if (m_write_finish !== 3'b010) begin
      n_bad++; $display("FAIL sp_still_wait: got %b want 010", m_write_finish);
    end
    step(); write_finish = 1'b0; m_write_req = '0;
  endtask

  // Random traffic; the model tracks only busy/free windows, the pointer and who is served.
  task automatic test_random();
    bit busy = 1'b0, no_resp = 1'b0, exp_wr = 1'b0, drop_wr = 1'b0, spur_ok;
    int free_cyc = 0, pulse_cyc = -100, resp_cyc = -100, exp_m = 0, ptr = 0, drop_m = -1;
    int kind, sz, idx;
    logic [31:0] rdat;
    logic [NM-1:0] v, exp_rv, exp_wf, exp_er;
    logic [1:0] exp_pulse;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) step();
      if (drop_m >= 0) begin
        if (drop_wr) m_write_req[drop_m] = 1'b0;
        else m_read_req[drop_m] = 1'b0;
        drop_m = -1;
      end
      for (int i = 0; i < NM; i++) begin
        if (!m_read_req[i] && !m_write_req[i] && $urandom_range(0, 3) == 0) begin
          kind = $urandom_range(0, 2);
          m_read_req[i] = (kind != 1);
          m_write_req[i] = (kind != 0);
          sz = $urandom_range(0, 2);
          m_read_w[i] = (sz == 2); m_read_hw[i] = (sz == 1);
          sz = $urandom_range(0, 2);
          m_write_w[i] = (sz == 2); m_write_hw[i] = (sz == 1);
          m_read_adr[32*i +: 32] = $urandom;
          m_write_adr[32*i +: 32] = $urandom;
          m_write_data[32*i +: 32] = $urandom;
        end
      end
      rdat = $urandom;
      read_data = rdat;
      spur_ok = !busy || (cyc <= pulse_cyc);
      if (busy && !no_resp && cyc == resp_cyc) begin
        read_valid = !exp_wr;
        write_finish = exp_wr;
      end else begin
        read_valid = ($urandom_range(0, 3) == 0) && (spur_ok || exp_wr);
        write_finish = ($urandom_range(0, 3) == 0) && (spur_ok || !exp_wr);
      end
      #1;
      v = m_read_req | m_write_req;
      exp_pulse = (busy && cyc == pulse_cyc) ? (exp_wr ? 2'b01 : 2'b10) : 2'b00;
      n_cmp++;
      if ({read_req, write_req} !== exp_pulse) begin
        n_bad++; $display("FAIL rnd_pulse@%0d: got %b want %b", cyc, {read_req, write_req}, exp_pulse);
      end
      if (busy && cyc == pulse_cyc) begin
        n_cmp++;
        if (exp_wr && {write_adr, write_data, write_w, write_hw} !==
            {m_write_adr[32*exp_m +: 32], m_write_data[32*exp_m +: 32],
             m_write_w[exp_m], m_write_hw[exp_m]}) begin
          n_bad++; $display("FAIL rnd_wfields@%0d: got adr %h want master %0d adr %h", cyc,
                            write_adr, exp_m, m_write_adr[32*exp_m +: 32]);
        end else if (!exp_wr && {read_adr, read_w, read_hw} !==
                     {m_read_adr[32*exp_m +: 32], m_read_w[exp_m], m_read_hw[exp_m]}) begin
          n_bad++; $display("FAIL rnd_rfields@%0d: got adr %h want master %0d adr %h", cyc,
                            read_adr, exp_m, m_read_adr[32*exp_m +: 32]);
        end
      end
      exp_rv = '0; exp_wf = '0; exp_er = '0;
      if (busy && !no_resp && cyc == resp_cyc) begin
        if (exp_wr) exp_wf[exp_m] = 1'b1;
        else exp_rv[exp_m] = 1'b1;
      end
      if (busy && no_resp && cyc == pulse_cyc + TO) exp_er[exp_m] = 1'b1;
      n_cmp++;
      if ({m_read_valid, m_write_finish, m_err} !== {exp_rv, exp_wf, exp_er}) begin
        n_bad++; $display("FAIL rnd_strobes@%0d: got %b want %b", cyc,
                          {m_read_valid, m_write_finish, m_err}, {exp_rv, exp_wf, exp_er});
      end
      if (exp_rv != '0) begin
        n_cmp++;
        if (m_read_data !== rdat) begin
          n_bad++; $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, m_read_data, rdat);
        end
      end
      if ({exp_rv, exp_wf, exp_er} != '0) begin
        busy = 1'b0;
        free_cyc = cyc + 2;
        ptr = (exp_m + 1) % NM;
        drop_m = exp_m;
        drop_wr = exp_wr;
      end
      if (!busy && cyc >= free_cyc && v != '0) begin
        exp_m = -1;
        for (int k = 0; k < NM; k++) begin
          idx = (ptr + k) % NM;
          if (exp_m < 0 && v[idx]) exp_m = idx;
        end
        exp_wr = m_write_req[exp_m];
        busy = 1'b1;
        pulse_cyc = cyc + 1;
        no_resp = ($urandom_range(0, 5) == 0);
        resp_cyc = pulse_cyc + $urandom_range(1, TO);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read_single();
    test_write_rr();
    test_both();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
